// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one single-port SRAM between the CPU MEM stage
// and a DMA/debug requester, with RISC-V sub-word store lanes and load alignment.
module dm_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [2:0]    cpu_funct3,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [3:0]    dma_be,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  output logic          DM_CS,
  output logic [3:0]    DM_WEB,
  output logic [AW-1:0] DM_A,
  output logic [31:0]   DM_DI,
  input  logic [31:0]   DM_DO
);

  // Handshake: a request is taken in the cycle it is presented unless cpu_stall
  // is high (CPU) or dma_gnt is low (DMA); read data follows exactly one cycle later.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] off;
  logic       legal;
  logic       cpu_issue;
  logic       dma_won;
  logic       cpu_grant;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_dma_q, tag_dma_d;
  logic [2:0] tag_funct3_q, tag_funct3_d;
  logic [1:0] tag_off_q, tag_off_d;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        unused_addr_hi;

  assign off            = cpu_addr[1:0];
  assign unused_addr_hi = ^cpu_addr[31:AW+2];

  always_comb begin
    legal = 1'b0;
    case (cpu_funct3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = !cpu_we;
      3'b001:  legal = !off[0];
      3'b101:  legal = !cpu_we && !off[0];
      3'b010:  legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // An illegal CPU request never reaches the port, so it cannot block the DMA either.
  assign cpu_issue = cpu_req & legal;
  assign cpu_err   = cpu_req & ~legal;
  assign dma_won   = dma_req & (~cpu_issue | (starve_cnt_q == STARVE_LIM));
  assign cpu_grant = cpu_issue & ~dma_won;
  assign cpu_stall = cpu_issue & dma_won;
  assign dma_gnt   = dma_won;

  always_comb begin
    DM_CS  = 1'b0;
    DM_WEB = 4'b1111;
    DM_A   = '0;
    DM_DI  = '0;
    if (dma_won) begin
      DM_CS = 1'b1;
      DM_A  = dma_addr;
      if (dma_we) begin
        DM_WEB = ~dma_be;
        DM_DI  = dma_wdata;
      end
    end else if (cpu_grant) begin
      DM_CS = 1'b1;
      DM_A  = cpu_addr[AW+1:2];
      if (cpu_we) begin
        case (cpu_funct3[1:0])
          2'b00: begin
            DM_WEB = ~(4'b0001 << off);
            DM_DI  = {4{cpu_wdata[7:0]}};
          end
          2'b01: begin
            DM_WEB = off[1] ? 4'b0011 : 4'b1100;
            DM_DI  = {2{cpu_wdata[15:0]}};
          end
          default: begin
            DM_WEB = 4'b0000;
            DM_DI  = cpu_wdata;
          end
        endcase
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_won)
      starve_cnt_d = '0;
    else if (cpu_grant && starve_cnt_q != STARVE_LIM)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // A DMA write with no byte enables is issued as a read whose data is dropped.
  always_comb begin
    tag_valid_d  = (dma_won && !dma_we) || (cpu_grant && !cpu_we);
    tag_dma_d    = dma_won;
    tag_funct3_d = cpu_funct3;
    tag_off_d    = off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      tag_valid_q  <= 1'b0;
      tag_dma_q    <= 1'b0;
      tag_funct3_q <= '0;
      tag_off_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_valid_q  <= tag_valid_d;
      tag_dma_q    <= tag_dma_d;
      tag_funct3_q <= tag_funct3_d;
      tag_off_q    <= tag_off_d;
    end
  end

  assign cpu_rvalid = tag_valid_q & ~tag_dma_q;
  assign dma_rvalid = tag_valid_q & tag_dma_q;
  assign dma_rdata  = dma_rvalid ? DM_DO : 32'h0;

  always_comb begin
    case (tag_off_q)
      2'd0:    rd_byte = DM_DO[7:0];
      2'd1:    rd_byte = DM_DO[15:8];
      2'd2:    rd_byte = DM_DO[23:16];
      default: rd_byte = DM_DO[31:24];
    endcase
    rd_half = tag_off_q[1] ? DM_DO[31:16] : DM_DO[15:0];
  end

  always_comb begin
    cpu_rdata = 32'h0;
    if (cpu_rvalid) begin
      case (tag_funct3_q)
        3'b000:  cpu_rdata = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  cpu_rdata = {24'h0, rd_byte};
        3'b001:  cpu_rdata = {{16{rd_half[15]}}, rd_half};
        3'b101:  cpu_rdata = {16'h0, rd_half};
        default: cpu_rdata = DM_DO;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a behavioural SRAM model.
module tb_dm_port_arbiter;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic [2:0]    cpu_funct3;
  logic          cpu_stall, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_be;
  logic [31:0]   dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [31:0]   dma_rdata;
  logic          DM_CS;
  logic [3:0]    DM_WEB;
  logic [AW-1:0] DM_A;
  logic [31:0]   DM_DI;
  logic [31:0]   DM_DO = 32'h0;

  logic [31:0] mem [0:63];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  dm_port_arbiter #(.STARVE_MAX(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .DM_CS(DM_CS), .DM_WEB(DM_WEB), .DM_A(DM_A), .DM_DI(DM_DI), .DM_DO(DM_DO)
  );

  // clock / SRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [31:0] w;
    if (DM_CS) begin
      w = mem[DM_A[5:0]];
      for (int i = 0; i < 4; i++)
        if (!DM_WEB[i]) w[8*i +: 8] = DM_DI[8*i +: 8];
      DM_DO <= mem[DM_A[5:0]];
      mem[DM_A[5:0]] <= w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_be = '0; dma_wdata = '0;
  endtask

  task automatic cpu_set(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_funct3 = f3;
  endtask

  task automatic dma_set(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_be = be; dma_wdata = wd;
  endtask

  task automatic cpu_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp);
    cpu_set(1'b0, addr, 32'h0, f3);
    #1;
    check({tag, "_cs"}, {31'h0, DM_CS}, 32'h1);
    check({tag, "_web"}, {28'h0, DM_WEB}, 32'hF);
    exp_q.push_back(exp);
    step();
    idle();
    check({tag, "_rvalid"}, {31'h0, cpu_rvalid}, 32'h1);
    check({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
  endtask

  task automatic cpu_bad(input string tag, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3);
    cpu_set(we, addr, 32'h5555_AAAA, f3);
    #1;
    check({tag, "_err"}, {31'h0, cpu_err}, 32'h1);
    check({tag, "_cs"}, {31'h0, DM_CS}, 32'h0);
    check({tag, "_stall"}, {31'h0, cpu_stall}, 32'h0);
    step();
    idle();
    check({tag, "_norv"}, {31'h0, cpu_rvalid}, 32'h0);
  endtask

  initial begin
    idle();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h8001_7FF0;
    #2;
    check("rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    check("rst_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);
    check("rst_starve", {28'h0, dut.starve_cnt_q}, 32'h0);
    check("idle_cs", {31'h0, DM_CS}, 32'h0);
    check("idle_web", {28'h0, DM_WEB}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: CPU loads with DMA idle
    cpu_load("lb", 32'h0, 3'b000, 32'hFFFF_FFF0);
    cpu_load("lbu", 32'h0, 3'b100, 32'h0000_00F0);
    cpu_load("lh", 32'h2, 3'b001, 32'hFFFF_8001);
    cpu_load("lhu", 32'h2, 3'b101, 32'h0000_8001);
    cpu_load("lw", 32'h0, 3'b010, 32'h8001_7FF0);
    cpu_load("lbu3", 32'h3, 3'b100, 32'h0000_0080);

    // 2: sub-word stores then read-back
    cpu_set(1'b1, 32'h7, 32'h0000_00AB, 3'b000);
    #1;
    check("sb_web", {28'h0, DM_WEB}, 32'h7);
    check("sb_di", DM_DI, 32'hABAB_ABAB);
    check("sb_a", {18'h0, DM_A}, 32'h1);
    step();
    cpu_set(1'b1, 32'h4, 32'h0000_1234, 3'b001);
    #1;
    check("sh_web", {28'h0, DM_WEB}, 32'hC);
    check("sh_di", DM_DI, 32'h1234_1234);
    step();
    check("st_norv", {31'h0, cpu_rvalid}, 32'h0);
    cpu_load("lw_after_st", 32'h4, 3'b010, 32'hAB00_1234);

    // 3: misaligned / illegal
    cpu_bad("lw_mis", 1'b0, 32'h2, 3'b010);
    cpu_bad("sh_mis", 1'b1, 32'h1, 3'b001);
    cpu_bad("st_f3_011", 1'b1, 32'h0, 3'b011);

    // 4: starvation bound, 4 CPU grants then 1 DMA grant
    cpu_set(1'b0, 32'h0, 32'h0, 3'b010);
    dma_set(1'b0, 14'd9, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("starve_gnt%0d", i), {31'h0, dma_gnt}, (i % 5 == 4) ? 32'h1 : 32'h0);
      check($sformatf("starve_stall%0d", i), {31'h0, cpu_stall}, (i % 5 == 4) ? 32'h1 : 32'h0);
      step();
    end
    idle();
    step();

    // 5: DMA-only traffic
    dma_set(1'b1, 14'd5, 4'b0101, 32'hFFFF_FFFF);
    #1;
    check("dma_wr_gnt", {31'h0, dma_gnt}, 32'h1);
    check("dma_wr_web", {28'h0, DM_WEB}, 32'hA);
    check("dma_wr_a", {18'h0, DM_A}, 32'h5);
    check("dma_wr_di", DM_DI, 32'hFFFF_FFFF);
    step();
    dma_set(1'b0, 14'd5, 4'b0000, 32'h0);
    #1;
    check("dma_wr_norv", {31'h0, dma_rvalid}, 32'h0);
    check("dma_rd_web", {28'h0, DM_WEB}, 32'hF);
    step();
    dma_set(1'b1, 14'd5, 4'b0000, 32'h1234_5678);
    check("dma_rd_rvalid", {31'h0, dma_rvalid}, 32'h1);
    check("dma_rd_data", dma_rdata, 32'h00FF_00FF);
    #1;
    check("dma_be0_cs", {31'h0, DM_CS}, 32'h1);
    check("dma_be0_web", {28'h0, DM_WEB}, 32'hF);
    step();
    idle();
    check("dma_be0_norv", {31'h0, dma_rvalid}, 32'h0);
    check("dma_be0_rdata0", dma_rdata, 32'h0);
    check("dma_be0_word", mem[5], 32'h00FF_00FF);

    // 6: reset while a read is in flight
    cpu_set(1'b0, 32'h4, 32'h0, 3'b010);
    dma_set(1'b0, 14'd9, 4'hF, 32'h0);
    step();
    step();
    check("pre_rst_starve", {28'h0, dut.starve_cnt_q}, 32'h2);
    check("pre_rst_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    check("rst_mid_starve", {28'h0, dut.starve_cnt_q}, 32'h0);
    idle();
    step();
    check("rst_mid_norv", {31'h0, cpu_rvalid}, 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    cpu_load("post_rst_lw", 32'h4, 3'b010, 32'hAB00_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
